// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS load path: opcodes, FSM states,
// and opcode classification helpers.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_LB  = 6'b100000,
        OP_LH  = 6'b100001,
        OP_LWL = 6'b100010,
        OP_LW  = 6'b100011,
        OP_LBU = 6'b100100,
        OP_LHU = 6'b100101,
        OP_LWR = 6'b100110
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FAULT   = 3'd4
    } load_state_t;

    localparam logic [3:0] BYTEEN_ALL = 4'b1111;

    function automatic logic is_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: ok = 1'b1;
            default:                                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // LWL/LWR are unaligned by design, so only halfword/word loads can trap.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            OP_LH, OP_LHU: mis = off[0];
            OP_LW:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_writeback_unit_if.sv
// Avalon-MM read-only master bus used by the load write-back unit.
interface load_writeback_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address, avm_read, avm_byteenable,
        input  avm_waitrequest, avm_readdata
    );

    modport slave (
        input  avm_address, avm_read, avm_byteenable,
        output avm_waitrequest, avm_readdata
    );
endinterface

// File: rtl/load_writeback_unit_aligner.sv
// Combinational lane extraction, sign/zero extension and LWL/LWR merge of a
// little-endian memory word into a 32-bit register value.
module load_aligner
    import mips_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    input  logic [31:0] i_rt_value,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword lanes.
    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_offset[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
    end

    // Build the register value for each load flavour.
    always_comb begin
        o_result = 32'h0000_0000;
        case (i_opcode)
            OP_LB:  o_result = {{24{w_byte[7]}}, w_byte};
            OP_LBU: o_result = {24'h00_0000, w_byte};
            OP_LH:  o_result = {{16{w_half[15]}}, w_half};
            OP_LHU: o_result = {16'h0000, w_half};
            OP_LW:  o_result = i_word;
            OP_LWL: begin
                case (i_offset)
                    2'd0:    o_result = {i_word[7:0],  i_rt_value[23:0]};
                    2'd1:    o_result = {i_word[15:0], i_rt_value[15:0]};
                    2'd2:    o_result = {i_word[23:0], i_rt_value[7:0]};
                    default: o_result = i_word;
                endcase
            end
            OP_LWR: begin
                case (i_offset)
                    2'd0:    o_result = i_word;
                    2'd1:    o_result = {i_rt_value[31:24], i_word[31:8]};
                    2'd2:    o_result = {i_rt_value[31:16], i_word[31:16]};
                    default: o_result = {i_rt_value[31:8],  i_word[31:24]};
                endcase
            end
            default: o_result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_writeback_unit.sv
// Memory-access and write-back phases of MIPS loads: one Avalon read, lane
// alignment, and a single-cycle register file write.
module load_writeback_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [4:0]        rt_index,
    input  logic [DATA_W-1:0] rt_value,
    load_writeback_unit_if.master avm,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              reg_write,
    output logic [4:0]        write_reg,
    output logic [DATA_W-1:0] write_data
);

    load_state_t       r_state;
    load_state_t       w_next_state;
    logic [5:0]        r_opcode;
    logic [ADDR_W-1:0] r_addr;
    logic [4:0]        r_rt_index;
    logic [DATA_W-1:0] r_rt_value;

    logic [ADDR_W-1:0] w_addr_src;
    logic [ADDR_W-1:0] w_address_nxt;
    logic              w_read_nxt;
    logic [3:0]        w_byteen_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_error_nxt;
    logic              w_reg_write_nxt;
    logic [4:0]        w_write_reg_nxt;
    logic [DATA_W-1:0] w_write_data_nxt;
    logic [DATA_W-1:0] w_aligned;

    load_aligner u_aligner (
        .i_opcode   (r_opcode),
        .i_offset   (r_addr[1:0]),
        .i_word     (avm.avm_readdata),
        .i_rt_value (r_rt_value),
        .o_result   (w_aligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch: captured only when a start is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_opcode   <= 6'd0;
            r_addr     <= '0;
            r_rt_index <= 5'd0;
            r_rt_value <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_opcode   <= opcode;
            r_addr     <= addr;
            r_rt_index <= rt_index;
            r_rt_value <= rt_value;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!start) begin
                    w_next_state = ST_IDLE;
                end else if (!is_supported(opcode) || is_misaligned(opcode, addr[1:0])) begin
                    w_next_state = ST_FAULT;
                end else begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                if (avm.avm_waitrequest) begin
                    w_next_state = ST_READ;
                end else begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: w_next_state = ST_WRITE;
            ST_WRITE:   w_next_state = ST_IDLE;
            ST_FAULT:   w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so every output is a flop aligned with r_state.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_addr_src = addr;
        end else begin
            w_addr_src = r_addr;
        end
        w_read_nxt       = (w_next_state == ST_READ);
        w_busy_nxt       = (w_next_state != ST_IDLE);
        w_done_nxt       = (w_next_state == ST_WRITE) || (w_next_state == ST_FAULT);
        w_error_nxt      = (w_next_state == ST_FAULT);
        w_address_nxt    = '0;
        w_byteen_nxt     = 4'b0000;
        w_reg_write_nxt  = 1'b0;
        w_write_reg_nxt  = 5'd0;
        w_write_data_nxt = '0;
        if (w_read_nxt) begin
            w_address_nxt = {w_addr_src[ADDR_W-1:2], 2'b00};
            w_byteen_nxt  = BYTEEN_ALL;
        end else begin
            w_address_nxt = '0;
            w_byteen_nxt  = 4'b0000;
        end
        if (w_next_state == ST_WRITE) begin
            w_reg_write_nxt  = (r_rt_index != 5'd0);
            w_write_reg_nxt  = r_rt_index;
            w_write_data_nxt = w_aligned;
        end else begin
            w_reg_write_nxt  = 1'b0;
            w_write_reg_nxt  = 5'd0;
            w_write_data_nxt = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avm.avm_address    <= '0;
            avm.avm_read       <= 1'b0;
            avm.avm_byteenable <= 4'b0000;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            reg_write          <= 1'b0;
            write_reg          <= 5'd0;
            write_data         <= '0;
        end else begin
            avm.avm_address    <= w_address_nxt;
            avm.avm_read       <= w_read_nxt;
            avm.avm_byteenable <= w_byteen_nxt;
            busy               <= w_busy_nxt;
            done               <= w_done_nxt;
            error              <= w_error_nxt;
            reg_write          <= w_reg_write_nxt;
            write_reg          <= w_write_reg_nxt;
            write_data         <= w_write_data_nxt;
        end
    end

endmodule
